// File: rtl/shift_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq_ctrl_pkg
// Description : Shift-type encodings, controller states and the effective
//               shift-count helper shared by the multi-cycle shifter.
// Revision    : 1.0
// ============================================================================
package shift_seq_ctrl_pkg;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int unsigned STEP_MAX = 8;

    // Clamp the register-specified amount to the count that actually matters.
    function automatic logic [5:0] eff_count(input logic [1:0] sh_type,
                                             input logic [7:0] amt);
        logic [5:0] n;
        case (sh_type)
            SH_LSL, SH_LSR: n = (amt > 8'd33) ? 6'd33 : amt[5:0];
            SH_ASR:         n = (amt > 8'd32) ? 6'd32 : amt[5:0];
            default:        n = ((amt[4:0] == 5'd0) && (amt != 8'd0)) ? 6'd32 : {1'b0, amt[4:0]};
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_seq_ctrl_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_step
// Description : Combinational 0..8 position shift of one type, returning the
//               shifted value and the last bit shifted out.
// Revision    : 1.0
// ============================================================================
module shift_step
    import shift_seq_ctrl_pkg::*;
(
    input  logic [1:0]  sh_type,
    input  logic [31:0] val_in,
    input  logic        fill,
    input  logic        carry_in,
    input  logic [3:0]  amt,
    output logic [31:0] val_out,
    output logic        carry_out
);

    logic [32:0] w_left;
    logic [7:0]  w_upper;
    logic [32:0] w_right;

    // The carry rides as an extra bit so amt=0 passes carry_in straight through.
    always_comb begin
        w_left  = {carry_in, val_in} << amt;
        w_upper = (sh_type == SH_ROR) ? val_in[7:0] : {8{fill}};
        w_right = 33'({w_upper, val_in, carry_in} >> amt);
        if (sh_type == SH_LSL) begin
            val_out   = w_left[31:0];
            carry_out = w_left[32];
        end else begin
            val_out   = w_right[32:1];
            carry_out = w_right[0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq_ctrl
// Description : Multi-cycle register-specified barrel shift, up to eight
//               positions per cycle, with flush and single-cycle done.
// Revision    : 1.0
// ============================================================================
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [1:0]  shift_type,
    input  logic [7:0]  shift_amt,
    input  logic [31:0] val_rm,
    input  logic        carry_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        carry_out
);

    logic [1:0]  state_q, state_d;
    logic [1:0]  type_q, type_d;
    logic [5:0]  rem_q, rem_d;
    logic [31:0] work_q, work_d;
    logic        wcarry_q, wcarry_d;
    logic [31:0] result_q, result_d;
    logic        cout_q, cout_d;

    logic [5:0]  n_eff;
    logic [3:0]  step_amt;
    logic        step_fill;
    logic [31:0] step_val;
    logic        step_carry;

    always_comb begin
        n_eff     = eff_count(shift_type, shift_amt);
        step_amt  = (rem_q > 6'(STEP_MAX)) ? 4'(STEP_MAX) : rem_q[3:0];
        step_fill = (type_q == SH_ASR) ? work_q[31] : 1'b0;
    end

    shift_step u_step (
        .sh_type   (type_q),
        .val_in    (work_q),
        .fill      (step_fill),
        .carry_in  (wcarry_q),
        .amt       (step_amt),
        .val_out   (step_val),
        .carry_out (step_carry)
    );

    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        rem_d    = rem_q;
        work_d   = work_q;
        wcarry_d = wcarry_q;
        result_d = result_q;
        cout_d   = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    type_d   = shift_type;
                    work_d   = val_rm;
                    wcarry_d = carry_in;
                    rem_d    = n_eff;
                    if (n_eff == 6'd0) begin
                        state_d  = ST_DONE;
                        result_d = val_rm;
                        cout_d   = carry_in;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                work_d   = step_val;
                wcarry_d = step_carry;
                rem_d    = rem_q - {2'b00, step_amt};
                // A flushed operation never reaches the visible result.
                if (flush) begin
                    state_d = ST_IDLE;
                    rem_d   = 6'd0;
                end else if (rem_d == 6'd0) begin
                    state_d  = ST_DONE;
                    result_d = step_val;
                    cout_d   = step_carry;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            type_q   <= SH_LSL;
            rem_q    <= 6'd0;
            work_q   <= 32'd0;
            wcarry_q <= 1'b0;
            result_q <= 32'd0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            rem_q    <= rem_d;
            work_q   <= work_d;
            wcarry_q <= wcarry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign result    = result_q;
    assign carry_out = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_shift_seq_ctrl
// Description : Scoreboard bench for shift_seq_ctrl with a reference model.
// Revision    : 1.0
// ============================================================================
module tb_shift_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [1:0]  shift_type;
    logic [7:0]  shift_amt;
    logic [31:0] val_rm;
    logic        carry_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        carry_out;

    shift_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .flush      (flush),
        .shift_type (shift_type),
        .shift_amt  (shift_amt),
        .val_rm     (val_rm),
        .carry_in   (carry_in),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .carry_out  (carry_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        c;
        int          scyc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] hold_res = 32'd0;
    logic        hold_c = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int eff_n(input logic [1:0] t, input logic [7:0] a);
        int ai;
        ai = int'(a);
        case (t)
            2'd0, 2'd1: return (ai > 33) ? 33 : ai;
            2'd2:       return (ai > 32) ? 32 : ai;
            default:    return ((ai % 32 == 0) && (ai != 0)) ? 32 : (ai % 32);
        endcase
    endfunction

    task automatic model(input logic [1:0] t, input logic [7:0] a, input logic [31:0] v,
                         input logic c, output logic [31:0] res, output logic co, output int lat);
        int          n;
        logic [63:0] w;
        n = eff_n(t, a);
        res = v;
        co  = c;
        if (n != 0) begin
            case (t)
                2'd0: begin w = {32'd0, v} << n;  res = w[31:0];  co = w[32]; end
                2'd1: begin w = {v, 32'd0} >> n;  res = w[63:32]; co = w[31]; end
                2'd2: begin w = $signed({v, 32'd0}) >>> n; res = w[63:32]; co = w[31]; end
                default: begin res = (v >> n) | (v << (32 - n)); co = res[31]; end
            endcase
        end
        lat = (n == 0) ? 1 : ((n + 7) / 8 + 1);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout pending=%0d got=no_done exp=done", sb.size());
            sb.delete();
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expected result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done got=done res=%h exp=no_done", result);
                end else begin
                    e = sb.pop_front();
                    if (result !== e.res || carry_out !== e.c || (cyc - e.scyc + 1) != e.lat) begin
                        errors++;
                        $display("FAIL op_result got res=%h c=%b lat=%0d exp res=%h c=%b lat=%0d",
                                 result, carry_out, cyc - e.scyc + 1, e.res, e.c, e.lat);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [1:0] t, input logic [7:0] a, input logic [31:0] v,
                         input logic c, input logic [31:0] er, input logic ec, input int el,
                         input bit hold, input bit fl);
        exp_t e;
        @(negedge clk);
        shift_type = t;
        shift_amt  = a;
        val_rm     = v;
        carry_in   = c;
        start      = 1'b1;
        e.res  = er;
        e.c    = ec;
        e.scyc = cyc + 1;
        e.lat  = el;
        sb.push_back(e);
        hold_res = er;
        hold_c   = ec;
        @(negedge clk);
        if (fl) begin
            start = 1'b0;
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
        end
        if (hold) begin
            for (int i = 1; i < el; i++) begin
                val_rm     = $urandom;
                shift_amt  = 8'($urandom);
                shift_type = 2'($urandom);
                carry_in   = 1'($urandom);
                @(negedge clk);
            end
        end
        start = 1'b0;
        wait_drain();
    endtask

    task automatic issue_model(input logic [1:0] t, input logic [7:0] a, input logic [31:0] v,
                               input logic c, input bit hold);
        logic [31:0] r;
        logic        co;
        int          l;
        model(t, a, v, c, r, co, l);
        issue(t, a, v, c, r, co, l, hold, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        shift_type = 2'd0; shift_amt = 8'd0; val_rm = 32'd0; carry_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_carry", {31'd0, carry_out}, 32'd0);
        rst = 1'b0;

        issue(2'd0, 8'd4,   32'h0000_0001, 1'b0, 32'h0000_0010, 1'b0, 2, 1'b0, 1'b0);
        issue(2'd1, 8'd32,  32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 5, 1'b0, 1'b0);
        issue(2'd1, 8'd40,  32'h8000_0000, 1'b1, 32'h0000_0000, 1'b0, 6, 1'b0, 1'b0);
        issue(2'd2, 8'd200, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 5, 1'b0, 1'b0);
        issue(2'd3, 8'd4,   32'h0000_00F1, 1'b1, 32'h1000_000F, 1'b0, 2, 1'b0, 1'b0);
        issue(2'd3, 8'd64,  32'h0000_00F1, 1'b1, 32'h0000_00F1, 1'b0, 5, 1'b0, 1'b0);
        issue(2'd0, 8'd32,  32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 5, 1'b0, 1'b0);
        issue(2'd2, 8'd32,  32'h4000_0000, 1'b1, 32'h0000_0000, 1'b0, 5, 1'b0, 1'b0);
        issue(2'd0, 8'd33,  32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 6, 1'b0, 1'b0);
        for (int t = 0; t < 4; t++)
            issue(2'(t), 8'd0, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 1, 1'b0, 1'b0);

        // start held through a busy operation must not queue a second one
        issue_model(2'd1, 8'd20, 32'hDEAD_BEEF, 1'b0, 1'b1);
        // flush while in DONE keeps the pulse and returns to IDLE
        issue(2'd0, 8'd0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 1, 1'b0, 1'b1);
        chk("flush_in_done_idle", {31'd0, busy}, 32'd0);

        // flush mid-operation with start held high
        @(negedge clk);
        shift_type = 2'd0; shift_amt = 8'd33; val_rm = 32'h5555_AAAA; carry_in = 1'b1; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_result_kept", result, hold_res);
        chk("flush_carry_kept", {31'd0, carry_out}, {31'd0, hold_c});
        @(negedge clk);
        chk("flush_start_ignored", {31'd0, busy}, 32'd0);
        flush = 1'b0; start = 1'b0;
        repeat (8) @(negedge clk);

        // asynchronous reset mid-operation
        shift_type = 2'd0; shift_amt = 8'd33; val_rm = 32'h0F0F_0F0F; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_carry", {31'd0, carry_out}, 32'd0);
        hold_res = 32'd0;
        hold_c   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom);
            issue_model(2'($urandom), a, $urandom, 1'($urandom), $urandom_range(0, 3) == 0);
        end

        repeat (5) @(negedge clk);
        chk("final_idle", {31'd0, busy}, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
